// File: rtl/commit_recovery_sequencer.sv
// commit_recovery_sequencer
// Accepts recovery requests from commit (exceptions/refetches) and from the
// backend (branch mispredicts), issues one refetch command and then walks the
// flushed active-list entries COMMIT_WIDTH per cycle for rename-map recovery.
module commit_recovery_sequencer #(
  parameter int COMMIT_WIDTH = 2,
  parameter int AL_CNT_W     = 6,
  parameter int REFETCH_W    = 3,
  parameter int CAUSE_W      = 4,
  parameter int PC_W         = 32,
  localparam int LANE_W      = (COMMIT_WIDTH > 1) ? $clog2(COMMIT_WIDTH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 exceptionDetectedInCommitStage,
  input  logic [REFETCH_W-1:0] refetchTypeFromCommitStage,
  input  logic [CAUSE_W-1:0]   recoveryCauseFromCommitStage,
  input  logic [LANE_W-1:0]    recoveryOpIndex,
  input  logic [PC_W-1:0]      commitRecoveryPC,
  input  logic                 backendMispredict,
  input  logic [PC_W-1:0]      backendRecoveryPC,
  input  logic [AL_CNT_W-1:0]  flushCount,
  input  logic                 recoveryStall,
  output logic [1:0]           phase,
  output logic                 unableToStartRecovery,
  output logic                 refetchValid,
  output logic [REFETCH_W-1:0] refetchType,
  output logic [PC_W-1:0]      refetchPC,
  output logic                 recoveryFromCommit,
  output logic [CAUSE_W-1:0]   recoveryCause,
  output logic [LANE_W-1:0]    recoveredLane,
  output logic                 renameLogicRecoveryRMT,
  output logic [LANE_W:0]      flushNum
);

  localparam logic [1:0] PH_COMMIT    = 2'd0;
  localparam logic [1:0] PH_RECOVER_0 = 2'd1;
  localparam logic [1:0] PH_RECOVER_1 = 2'd2;

  localparam logic [REFETCH_W-1:0] REFETCH_BRANCH_TARGET = REFETCH_W'(1);
  localparam logic [AL_CNT_W-1:0]  WALK_MAX_CNT          = AL_CNT_W'(COMMIT_WIDTH);
  localparam logic [LANE_W:0]      WALK_MAX_NUM          = (LANE_W + 1)'(COMMIT_WIDTH);

  logic [1:0]          phaseNext;
  logic [AL_CNT_W-1:0] remaining;
  logic                acceptReq;
  logic                canAccept;

  // Requests are only taken in COMMIT with no store drain pending; this gate
  // depends on registered phase and the stall input only.
  assign canAccept             = (phase == PH_COMMIT) && !recoveryStall;
  assign unableToStartRecovery = !canAccept;
  assign acceptReq             = canAccept && (exceptionDetectedInCommitStage || backendMispredict);

  // Phase state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase <= PH_COMMIT;
    end else begin
      phase <= phaseNext;
    end
  end

  // Next-phase selection: one RECOVER_0 cycle, then walk until the count is exhausted.
  always_comb begin
    phaseNext = phase;
    case (phase)
      PH_COMMIT:    phaseNext = acceptReq ? PH_RECOVER_0 : PH_COMMIT;
      PH_RECOVER_0: phaseNext = (remaining != '0) ? PH_RECOVER_1 : PH_COMMIT;
      PH_RECOVER_1: phaseNext = (remaining <= WALK_MAX_CNT) ? PH_COMMIT : PH_RECOVER_1;
      default:      phaseNext = PH_COMMIT;
    endcase
  end

  // Phase-qualified outputs: refetch pulse in RECOVER_0, rename walk in RECOVER_1.
  always_comb begin
    refetchValid           = 1'b0;
    renameLogicRecoveryRMT = 1'b0;
    flushNum               = '0;
    if (phase == PH_RECOVER_0) begin
      refetchValid = 1'b1;
    end
    if (phase == PH_RECOVER_1) begin
      renameLogicRecoveryRMT = 1'b1;
      flushNum = (remaining >= WALK_MAX_CNT) ? WALK_MAX_NUM : remaining[LANE_W:0];
    end
  end

  // Latch the accepted request (commit wins over backend) and count down the walk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      remaining          <= '0;
      refetchType        <= '0;
      refetchPC          <= '0;
      recoveryFromCommit <= 1'b0;
      recoveryCause      <= '0;
      recoveredLane      <= '0;
    end else if (acceptReq) begin
      remaining     <= flushCount;
      recoveredLane <= recoveryOpIndex;
      if (exceptionDetectedInCommitStage) begin
        refetchType        <= refetchTypeFromCommitStage;
        refetchPC          <= commitRecoveryPC;
        recoveryFromCommit <= 1'b1;
        recoveryCause      <= recoveryCauseFromCommitStage;
      end else begin
        refetchType        <= REFETCH_BRANCH_TARGET;
        refetchPC          <= backendRecoveryPC;
        recoveryFromCommit <= 1'b0;
        recoveryCause      <= '0;
      end
    end else if (phase == PH_RECOVER_1) begin
      // flushNum never exceeds remaining, so this cannot wrap.
      remaining <= remaining - AL_CNT_W'(flushNum);
    end
  end

  // Structural invariants of the sequencer.
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (flushNum <= WALK_MAX_NUM);
      assert (!refetchValid || (phase == PH_RECOVER_0));
      assert (phase != 2'd3);
    end
  end

endmodule

// File: tb/tb_commit_recovery_sequencer.sv
// Directed bench for commit_recovery_sequencer (COMMIT_WIDTH = 2).
module tb_commit_recovery_sequencer;

  logic        clk;
  logic        rst;
  logic        exceptionDetectedInCommitStage;
  logic [2:0]  refetchTypeFromCommitStage;
  logic [3:0]  recoveryCauseFromCommitStage;
  logic [0:0]  recoveryOpIndex;
  logic [31:0] commitRecoveryPC;
  logic        backendMispredict;
  logic [31:0] backendRecoveryPC;
  logic [5:0]  flushCount;
  logic        recoveryStall;
  logic [1:0]  phase;
  logic        unableToStartRecovery;
  logic        refetchValid;
  logic [2:0]  refetchType;
  logic [31:0] refetchPC;
  logic        recoveryFromCommit;
  logic [3:0]  recoveryCause;
  logic [0:0]  recoveredLane;
  logic        renameLogicRecoveryRMT;
  logic [1:0]  flushNum;

  int testsRun = 0;
  int testsFailed = 0;

  commit_recovery_sequencer #(
    .COMMIT_WIDTH(2), .AL_CNT_W(6), .REFETCH_W(3), .CAUSE_W(4), .PC_W(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .exceptionDetectedInCommitStage(exceptionDetectedInCommitStage),
    .refetchTypeFromCommitStage(refetchTypeFromCommitStage),
    .recoveryCauseFromCommitStage(recoveryCauseFromCommitStage),
    .recoveryOpIndex(recoveryOpIndex),
    .commitRecoveryPC(commitRecoveryPC),
    .backendMispredict(backendMispredict),
    .backendRecoveryPC(backendRecoveryPC),
    .flushCount(flushCount),
    .recoveryStall(recoveryStall),
    .phase(phase),
    .unableToStartRecovery(unableToStartRecovery),
    .refetchValid(refetchValid),
    .refetchType(refetchType),
    .refetchPC(refetchPC),
    .recoveryFromCommit(recoveryFromCommit),
    .recoveryCause(recoveryCause),
    .recoveredLane(recoveredLane),
    .renameLogicRecoveryRMT(renameLogicRecoveryRMT),
    .flushNum(flushNum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected)
      else begin
        testsFailed++;
        $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  // Advance one clock and settle just after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    exceptionDetectedInCommitStage = 1'b0;
    refetchTypeFromCommitStage = '0;
    recoveryCauseFromCommitStage = '0;
    recoveryOpIndex = '0;
    commitRecoveryPC = '0;
    backendMispredict = 1'b0;
    backendRecoveryPC = '0;
    flushCount = '0;
    recoveryStall = 1'b1;

    // Reset state
    #2;
    check("rst_phase", 32'(phase), 0);
    check("rst_refetchValid", 32'(refetchValid), 0);
    check("rst_flushNum", 32'(flushNum), 0);
    check("rst_unable_stall1", 32'(unableToStartRecovery), 1);
    recoveryStall = 1'b0;
    #1;
    check("rst_unable_stall0", 32'(unableToStartRecovery), 0);
    step();
    step();
    rst = 1'b1;
    step();

    // Commit request, flushCount 5: walk 2,2,1
    exceptionDetectedInCommitStage = 1'b1;
    refetchTypeFromCommitStage = 3'd2;
    recoveryCauseFromCommitStage = 4'd3;
    recoveryOpIndex = 1'b1;
    commitRecoveryPC = 32'h1000;
    flushCount = 6'd5;
    step();
    exceptionDetectedInCommitStage = 1'b0;
    check("c1_phase", 32'(phase), 1);
    check("c1_refetchValid", 32'(refetchValid), 1);
    check("c1_refetchPC", refetchPC, 32'h1000);
    check("c1_refetchType", 32'(refetchType), 2);
    check("c1_fromCommit", 32'(recoveryFromCommit), 1);
    check("c1_cause", 32'(recoveryCause), 3);
    check("c1_lane", 32'(recoveredLane), 1);
    check("c1_flushNum", 32'(flushNum), 0);
    check("c1_unable", 32'(unableToStartRecovery), 1);
    step();
    check("c2_phase", 32'(phase), 2);
    check("c2_flushNum", 32'(flushNum), 2);
    check("c2_rmt", 32'(renameLogicRecoveryRMT), 1);
    check("c2_refetchValid", 32'(refetchValid), 0);
    step();
    check("c3_flushNum", 32'(flushNum), 2);
    step();
    check("c4_flushNum", 32'(flushNum), 1);
    check("c4_phase", 32'(phase), 2);
    step();
    check("c5_phase", 32'(phase), 0);
    check("c5_flushNum", 32'(flushNum), 0);
    check("c5_rmt", 32'(renameLogicRecoveryRMT), 0);
    check("c5_heldPC", refetchPC, 32'h1000);

    // Simultaneous requests with zero-entry flush: commit wins
    exceptionDetectedInCommitStage = 1'b1;
    refetchTypeFromCommitStage = 3'd4;
    recoveryCauseFromCommitStage = 4'd5;
    recoveryOpIndex = 1'b0;
    commitRecoveryPC = 32'h2000;
    backendMispredict = 1'b1;
    backendRecoveryPC = 32'h3000;
    flushCount = 6'd0;
    step();
    exceptionDetectedInCommitStage = 1'b0;
    backendMispredict = 1'b0;
    check("s1_phase", 32'(phase), 1);
    check("s1_refetchPC", refetchPC, 32'h2000);
    check("s1_fromCommit", 32'(recoveryFromCommit), 1);
    check("s1_refetchType", 32'(refetchType), 4);
    check("s1_rmt", 32'(renameLogicRecoveryRMT), 0);
    step();
    check("s2_phase", 32'(phase), 0);
    check("s2_rmt", 32'(renameLogicRecoveryRMT), 0);
    step();
    check("s3_phase", 32'(phase), 0);
    check("s3_refetchValid", 32'(refetchValid), 0);
    check("s3_heldPC", refetchPC, 32'h2000);

    // Backend request while stalled is dropped
    recoveryStall = 1'b1;
    backendMispredict = 1'b1;
    backendRecoveryPC = 32'h4000;
    flushCount = 6'd3;
    #1;
    check("st_unable", 32'(unableToStartRecovery), 1);
    step();
    check("st_phase", 32'(phase), 0);
    check("st_refetchValid", 32'(refetchValid), 0);
    check("st_heldPC", refetchPC, 32'h2000);

    // Stall released: backend request accepted, flushCount 3
    recoveryStall = 1'b0;
    step();
    backendMispredict = 1'b0;
    check("b1_phase", 32'(phase), 1);
    check("b1_refetchPC", refetchPC, 32'h4000);
    check("b1_refetchType", 32'(refetchType), 1);
    check("b1_fromCommit", 32'(recoveryFromCommit), 0);
    check("b1_cause", 32'(recoveryCause), 0);
    step();
    check("b2_flushNum", 32'(flushNum), 2);
    // Request during RECOVER_1 must be dropped
    exceptionDetectedInCommitStage = 1'b1;
    commitRecoveryPC = 32'h5000;
    flushCount = 6'd4;
    #1;
    check("b2_unable", 32'(unableToStartRecovery), 1);
    step();
    check("b3_phase", 32'(phase), 2);
    check("b3_flushNum", 32'(flushNum), 1);
    check("b3_unable", 32'(unableToStartRecovery), 1);
    check("b3_heldPC", refetchPC, 32'h4000);
    exceptionDetectedInCommitStage = 1'b0;
    step();
    check("b4_phase", 32'(phase), 0);
    check("b4_heldPC", refetchPC, 32'h4000);

    // Reset in the middle of a walk with remaining = 3
    exceptionDetectedInCommitStage = 1'b1;
    refetchTypeFromCommitStage = 3'd2;
    recoveryCauseFromCommitStage = 4'd7;
    commitRecoveryPC = 32'h6000;
    flushCount = 6'd5;
    step();
    exceptionDetectedInCommitStage = 1'b0;
    step();
    step();
    check("r0_flushNum", 32'(flushNum), 2);
    rst = 1'b0;
    #1;
    check("r1_phase", 32'(phase), 0);
    check("r1_flushNum", 32'(flushNum), 0);
    check("r1_rmt", 32'(renameLogicRecoveryRMT), 0);
    check("r1_refetchPC", refetchPC, 0);
    check("r1_fromCommit", 32'(recoveryFromCommit), 0);
    check("r1_cause", 32'(recoveryCause), 0);
    step();
    rst = 1'b1;
    step();
    check("r2_phase", 32'(phase), 0);

    // Fresh request after reset: single walk of 2
    exceptionDetectedInCommitStage = 1'b1;
    commitRecoveryPC = 32'h7000;
    flushCount = 6'd2;
    step();
    exceptionDetectedInCommitStage = 1'b0;
    check("n1_refetchPC", refetchPC, 32'h7000);
    check("n1_refetchValid", 32'(refetchValid), 1);
    step();
    check("n2_flushNum", 32'(flushNum), 2);
    step();
    check("n3_phase", 32'(phase), 0);
    check("n3_flushNum", 32'(flushNum), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/commit_recovery_sequencer.md
# commit_recovery_sequencer

Recovery-side responder to the commit stage: accepts recovery requests raised at commit (exceptions, refetches) and by the backend (branch mispredicts) and drives the pipeline phase (COMMIT / RECOVER_0 / RECOVER_1) back to the commit stage. It gates new requests through `unableToStartRecovery`, issues a single refetch command to the fetch side, and walks the flushed active-list entries `COMMIT_WIDTH` per cycle for rename-map recovery. It sits between the commit stage, the execute-stage branch resolver, the rename logic and the fetch unit.

## Interface
- `COMMIT_WIDTH`, 2: maximum number of active-list entries walked per cycle.
- `AL_CNT_W`, 6: width of the active-list entry count.
- `REFETCH_W`, 3: width of the refetch-type encoding.
- `CAUSE_W`, 4: width of the execution-state / cause encoding.
- `PC_W`, 32: width of a PC.
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, asynchronous, active-low.
- `exceptionDetectedInCommitStage`, in, 1: commit-stage recovery request.
- `refetchTypeFromCommitStage`, in, `REFETCH_W`: refetch type of the commit request.
- `recoveryCauseFromCommitStage`, in, `CAUSE_W`: cause of the commit request.
- `recoveryOpIndex`, in, clog2(`COMMIT_WIDTH`): lane of the recovered op.
- `commitRecoveryPC`, in, `PC_W`: PC of the recovered op.
- `backendMispredict`, in, 1: backend recovery request.
- `backendRecoveryPC`, in, `PC_W`: target PC for the backend request.
- `flushCount`, in, `AL_CNT_W`: entries to flush, valid in the cycle a request is accepted.
- `recoveryStall`, in, 1: store drain in progress; blocks acceptance of new requests.
- `phase`, out, 2: 0 = COMMIT, 1 = RECOVER_0, 2 = RECOVER_1.
- `unableToStartRecovery`, out, 1: combinational; equals (`phase` != COMMIT) | `recoveryStall`.
- `refetchValid`, out, 1: one-cycle pulse carrying the refetch command.
- `refetchType`, out, `REFETCH_W`: refetch type. Backend requests use type 1 (BRANCH_TARGET).
- `refetchPC`, out, `PC_W`: refetch PC.
- `recoveryFromCommit`, out, 1: latched source of the recovery in progress; 1 = commit stage.
- `recoveryCause`, out, `CAUSE_W`: latched cause. Backend requests latch 0.
- `recoveredLane`, out, clog2(`COMMIT_WIDTH`): latched `recoveryOpIndex`.
- `renameLogicRecoveryRMT`, out, 1: high in every RECOVER_1 cycle.
- `flushNum`, out, clog2(`COMMIT_WIDTH`)+1: entries walked this cycle. Zero outside RECOVER_1.

## Operation
- **Acceptance.** A request is accepted only when `phase` == COMMIT and `recoveryStall` == 0.
  - Requests arriving at any other time are dropped; requesters re-raise them.
- **Priority.** If both sources request in the same cycle, the commit request wins (it is older) and the backend request is discarded.
- **On accept (registered at clk edge):**
  - latch the type, PC, cause, lane, source and `flushCount` into the `remaining` counter;
  - set `phase` = RECOVER_0.
- **RECOVER_0 (exactly 1 cycle):**
  - `refetchValid` = 1, driven from the latched values;
  - next state: RECOVER_1 if `remaining` != 0, else COMMIT.
- **RECOVER_1:**
  - `flushNum` = min(`remaining`, `COMMIT_WIDTH`);
  - `remaining` -= `flushNum` at the clock edge;
  - return to COMMIT after the cycle in which `remaining` <= `COMMIT_WIDTH`.
- **Counter width.** `remaining` is `AL_CNT_W` bits and cannot underflow, because `flushNum` never exceeds it.
- **Latched outputs.** These hold their values until the next accepted request. Only `refetchValid`, `flushNum` and `renameLogicRecoveryRMT` are phase-qualified.
- **Reset.** Asynchronous reset, including in the middle of a walk, forces:
  - `phase` = COMMIT and `remaining` = 0;
  - all latched outputs = 0;
  - `refetchValid`, `renameLogicRecoveryRMT` and `flushNum` = 0.
- **Assertions:**
  - `flushNum` <= `COMMIT_WIDTH`;
  - no `refetchValid` outside RECOVER_0;
  - `phase` is never 3.

## Timing
- Request accepted at edge N → RECOVER_0 in cycle N+1 (`refetchValid` high) → RECOVER_1 from cycle N+2.
- Total recovery duration is 1 + ceil(`flushCount`/`COMMIT_WIDTH`) cycles. `phase` = COMMIT again in the cycle after the last walk.
- A new request is accepted no earlier than the first COMMIT cycle after recovery (back-to-back recovery allowed there).
- `unableToStartRecovery` is combinational from registered `phase` and the `recoveryStall` input. It is valid in the same cycle and has no path to the request inputs.

## Test plan
- **Reset state:** hold `rst` low → `phase` = 0, `refetchValid` = 0, `flushNum` = 0, `unableToStartRecovery` = `recoveryStall`.
- **Commit request with a partial last walk:** request with `flushCount` = 5, type 2, PC 0x1000, `COMMIT_WIDTH` = 2.
  - Cycle +1: `refetchValid`, PC 0x1000.
  - `flushNum` sequence 2, 2, 1, then `phase` = 0 on cycle +5.
- **Simultaneous requests:** commit and backend request in the same cycle → `recoveryFromCommit` = 1 and `refetchPC` = `commitRecoveryPC`; the backend request is never serviced.
- **Stall and phase gating:**
  - backend request while `recoveryStall` = 1 → ignored, `phase` stays 0;
  - request during RECOVER_1 → ignored; `unableToStartRecovery` = 1 throughout the recovery.
- **Zero-entry flush:** `flushCount` = 0 → RECOVER_0 for one cycle, then COMMIT; `renameLogicRecoveryRMT` never asserts.
- **Reset mid-walk:** assert reset mid-walk with `remaining` = 3, then release and issue a new request with `flushCount` = 2 → walk shows a single `flushNum` of 2 and no stale count.
